// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with clear, load, terminal flags and wrap pulse.
// Define BCD_CNTR_SAT_EN to saturate at all-9s / all-0s instead of wrapping.

module bcd_counter_chain_digit (
  input  logic [3:0] d,
  input  logic       step,
  input  logic       up,
  input  logic [3:0] ld,
  output logic [3:0] nxt,
  output logic [3:0] ld_clip,
  output logic       is9,
  output logic       is0
);
  assign is9     = (d == 4'd9);
  assign is0     = (d == 4'd0);
  assign ld_clip = (ld > 4'd9) ? 4'd9 : ld;

  always_comb begin
    nxt = d;
    if (step) begin
      if (up) nxt = is9 ? 4'd0 : d + 4'd1;
      else    nxt = is0 ? 4'd9 : d - 4'd1;
    end
  end
endmodule

module bcd_counter_chain #(
  parameter int          DIGITS    = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] ld_val,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] q,
  output logic                at_max,
  output logic                at_min,
  output logic                carry,
  output logic                borrow,
  output logic                wrap
);
  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    int unsigned r;
    r      = v;
    to_bcd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      to_bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  localparam logic [4*DIGITS-1:0] RST_BCD = to_bcd(RESET_VAL);

  logic [DIGITS-1:0][3:0] cnt, cnt_step, ld_clip;
  logic [DIGITS-1:0]      is9, is0, step;
  // all9[k] / all0[k]: every digit below k is 9 / 0 (ripple enable for digit k)
  logic [DIGITS:0]        all9, all0;

  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign all9[k+1] = all9[k] & is9[k];
    assign all0[k+1] = all0[k] & is0[k];
    assign step[k]   = up ? all9[k] : all0[k];

    bcd_counter_chain_digit u_digit (
      .d       (cnt[k]),
      .step    (step[k]),
      .up      (up),
      .ld      (ld_val[4*k +: 4]),
      .nxt     (cnt_step[k]),
      .ld_clip (ld_clip[k]),
      .is9     (is9[k]),
      .is0     (is0[k])
    );
  end

  assign q      = cnt;
  assign at_max = all9[DIGITS];
  assign at_min = all0[DIGITS];
  assign carry  = en & up & at_max;
  assign borrow = en & ~up & at_min;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= RST_BCD;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt  <= ld_clip;
      wrap <= 1'b0;
    end else if (en) begin
`ifdef BCD_CNTR_SAT_EN
      // terminal state with count request: hold instead of rolling over
      cnt  <= (carry | borrow) ? cnt : cnt_step;
      wrap <= 1'b0;
`else
      cnt  <= cnt_step;
      wrap <= carry | borrow;
`endif
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench for bcd_counter_chain: integer-valued reference model,
// directed corner sequence followed by randomized traffic.

module tb_bcd_counter_chain;
  localparam int          DIGITS    = 4;
  localparam int unsigned RESET_VAL = 4071;
  localparam int unsigned MAXV      = 9999;
  localparam int          W         = 4*DIGITS;

  logic         clk = 1'b0;
  logic         reset, clr, load, en, up;
  logic [W-1:0] ld_val;
  logic [W-1:0] q;
  logic         at_max, at_min, carry, borrow, wrap;

  bcd_counter_chain #(.DIGITS(DIGITS), .RESET_VAL(RESET_VAL)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .ld_val(ld_val),
    .en(en), .up(up), .q(q), .at_max(at_max), .at_min(at_min),
    .carry(carry), .borrow(borrow), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         wrap, at_max, at_min, carry, borrow;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // reference state: plain integer value plus the pending wrap pulse
  int unsigned mv;
  bit          mw;

  function automatic logic [W-1:0] int2bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int unsigned ld2int(input logic [W-1:0] b);
    int unsigned v, d;
    v = 0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      d = int'(b[4*k +: 4]);
      if (d > 9) d = 9;
      v = v*10 + d;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Apply inputs for the coming edge; record what the DUT shows this cycle,
  // then advance the model across that edge.
  task automatic step(input bit r, input bit c, input bit l, input logic [W-1:0] lv,
                      input bit e, input bit u);
    exp_t x;
    @(posedge clk);
    #2;
    reset = r; clr = c; load = l; ld_val = lv; en = e; up = u;
    if (r) begin
      mv = RESET_VAL;
      mw = 0;
    end
    x.q      = int2bcd(mv);
    x.wrap   = mw;
    x.at_max = (mv == MAXV);
    x.at_min = (mv == 0);
    x.carry  = e & u & (mv == MAXV);
    x.borrow = e & ~u & (mv == 0);
    sb.push_back(x);
    if (r) begin
      mv = RESET_VAL;
      mw = 0;
    end else if (c) begin
      mv = 0;
      mw = 0;
    end else if (l) begin
      mv = ld2int(lv);
      mw = 0;
    end else if (e) begin
      if (u && mv == MAXV) begin
`ifdef BCD_CNTR_SAT_EN
        mw = 0;
`else
        mv = 0; mw = 1;
`endif
      end else if (!u && mv == 0) begin
`ifdef BCD_CNTR_SAT_EN
        mw = 0;
`else
        mv = MAXV; mw = 1;
`endif
      end else begin
        mv = u ? mv + 1 : mv - 1;
        mw = 0;
      end
    end else begin
      mw = 0;
    end
  endtask

  // monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q",      q,              x.q);
        chk("wrap",   W'(wrap),       W'(x.wrap));
        chk("at_max", W'(at_max),     W'(x.at_max));
        chk("at_min", W'(at_min),     W'(x.at_min));
        chk("carry",  W'(carry),      W'(x.carry));
        chk("borrow", W'(borrow),     W'(x.borrow));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rv;
    int unsigned  sel;
    reset = 1'b1; clr = 0; load = 0; ld_val = '0; en = 0; up = 1;
    mv = RESET_VAL; mw = 0;

    step(1, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    repeat (5) step(0, 0, 0, '0, 1, 1);
    // asynchronous reset mid-count, observed before any edge
    step(1, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    repeat (3) step(0, 0, 0, '0, 1, 1);
    // carry ripple through several digits, both directions
    step(0, 0, 1, 16'h0999, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 0, 0);
    // downward wrap from all zeros
    step(0, 0, 1, 16'h0000, 0, 0);
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    // priority: clr over load over en
    step(0, 1, 1, 16'h1234, 1, 1);
    step(0, 0, 1, 16'h1234, 1, 1);
    step(0, 0, 0, '0, 0, 1);
    // out-of-range digits clipped on load, then hold
    step(0, 0, 1, 16'hA5F3, 0, 1);
    repeat (10) step(0, 0, 0, '0, 0, 1);
    // upward wrap from near the top
    step(0, 0, 1, 16'h9990, 1, 1);
    repeat (14) step(0, 0, 0, '0, 1, 1);
    step(0, 0, 1, 16'h9999, 1, 1);
    repeat (3) step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      rv  = W'($urandom);
      if (($urandom_range(0, 3)) == 0)
        rv = ($urandom_range(0, 1) == 0) ? 16'h9998 : 16'h0001;
      if (sel < 1)       step(1, 0, 0, rv, 1, 1);
      else if (sel < 5)  step(0, 1, $urandom_range(0, 1) == 1, rv, 1, $urandom_range(0, 1) == 1);
      else if (sel < 14) step(0, 0, 1, rv, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else if (sel < 80) step(0, 0, 0, rv, 1, $urandom_range(0, 5) != 0);
      else               step(0, 0, 0, rv, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
